ifid_skid_reg: RTL and testbench
================================

// Module: ifid_skid_reg
// PURPOSE
// - Next-generation IF/ID pipeline register between fetch and decode.
// - Adds a valid/ready handshake, a 2-entry skid buffer (main + skid), flush and a parametrised PC width.
// - Latches each fetched instruction with its PC+4 and presents decoded fields: opcode, rs, rt, rd, imm16, jump target.
// - Sustains 1 instr/cycle under back-pressure with no combinational ready path from out_ready to in_ready.
// PARAMETERS
// - PC_W       32      width of in_pc4/out_pc4 (fetch PC+4)
// - NOP_INSTR  32'h0   instruction word driven on out_instr while the stage holds a bubble
// - CNT_W      16      width of perf counters (only used with IFID_PERF_CNT_EN)
// PORTS
// - clk          in   1      rising-edge clock
// - rst_n        in   1      synchronous reset, active low
// - in_valid     in   1      fetch presents a valid instruction
// - in_ready     out  1      stage can accept; equals !skid_valid (registered state only)
// - in_instr     in   32     fetched instruction word
// - in_pc4       in   PC_W   PC+4 of in_instr
// - flush        in   1      kill all held instructions (branch/jump redirect)
// - out_valid    out  1      main entry holds a valid instruction
// - out_ready    in   1      decode accepts main entry this cycle
// - out_instr    out  32     main entry instruction (NOP_INSTR when bubble)
// - out_pc4      out  PC_W   main entry PC+4
// - out_opcode   out  6      out_instr[31:26]
// - out_rs       out  5      out_instr[25:21]
// - out_rt       out  5      out_instr[20:16]
// - out_rd       out  5      out_instr[15:11]
// - out_imm      out  16     out_instr[15:0]
// - out_jtarget  out  26     out_instr[25:0]
// - stall_cnt    out  CNT_W  cycles with out_valid && !out_ready (macro only)
// - flush_cnt    out  CNT_W  count of flushes that killed >=1 valid entry (macro only)
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): main_valid=skid_valid=0, out_instr=NOP_INSTR, out_pc4=0, counters=0; in_ready=1 after.
// - Accept = in_valid && in_ready. Drain = out_valid && out_ready. Decode fields are pure slices of main register.
// - Latency: accepted instr appears on out_* the cycle after acceptance when main is empty or draining.
// - Main load (main empty or draining): from skid if skid_valid, else from input if accept; else main_valid<=0, out_instr<=NOP_INSTR.
// - Main full and not draining and accept: input goes to skid; in_ready drops next cycle.
// - Main draining, skid_valid and accept: skid->main, input->skid (skid stays full, in_ready stays 0).
// - Skid cleared whenever it moves to main without refill. Order strictly FIFO; no entry dropped or duplicated.
// - Flush (highest priority after reset): next cycle main_valid=skid_valid=0, out_instr=NOP_INSTR; same-cycle accept is discarded; out_pc4 holds.
// - Drain in the flush cycle still counts as a transfer for decode (decode owns that instr).
// - in_ready never depends on out_ready or flush combinationally.
// CONFIGURATION
// - IFID_PERF_CNT_EN defined: stall_cnt/flush_cnt ports exist; both saturate at all-ones; cleared by reset only.
// - IFID_PERF_CNT_EN undefined: ports and counter logic absent; all other behaviour identical.
// TESTING
// - Reset: hold rst_n=0 2 cycles with in_valid=1 -> out_valid=0, out_instr=0, in_ready=1 after release.
// - Stream: out_ready=1, in_instr=32'h8C220004,pc4=0x104 -> next cycle out_opcode=0x23, rs=1, rt=2, imm=0x0004, pc4=0x104.
// - Back-pressure: out_ready=0, send A,B -> A on out, B in skid, in_ready=0; C held by fetch; out_ready=1 -> A,B,C in order.
// - Flush with full skid: A in main, B in skid, flush=1 with in_valid -> next cycle out_valid=0, in_ready=1, out_instr=NOP_INSTR.
// - Reset mid-stall: main+skid full, rst_n=0 one cycle -> both empty, no instr replayed.
// - Perf (macro on): 5 stall cycles then 1 flush of valid entry -> stall_cnt=5, flush_cnt=1; flush on empty stage leaves flush_cnt=1.

Source files
------------

// File: rtl/ifid_skid_reg.sv
// ==========================================================================
// ifid_skid_reg : IF/ID pipeline register with valid/ready and 2-entry skid
// Optional perf counters enabled by defining IFID_PERF_CNT_EN.   Rev 1.0
// ==========================================================================
`default_nettype none

module ifid_skid_reg #(
  parameter int unsigned PC_W      = 32,
  parameter logic [31:0] NOP_INSTR = 32'h0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc4,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc4,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [15:0]     out_imm,
  output logic [25:0]     out_jtarget
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic            main_valid;
  logic [31:0]     main_instr;
  logic [PC_W-1:0] main_pc4;
  logic            skid_valid;
  logic [31:0]     skid_instr;
  logic [PC_W-1:0] skid_pc4;

  logic accept;
  logic drain;
  logic main_free;

  generate
    if (CNT_W < 1) begin : g_cnt_w_check
      $error("CNT_W must be at least 1");
    end
  endgenerate

  // in_ready comes from registered skid state only, so there is no
  // combinational path from out_ready or flush back to fetch.
  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign drain     = main_valid && out_ready;
  assign main_free = !main_valid || drain;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid <= 1'b0;
      main_instr <= NOP_INSTR;
      main_pc4   <= '0;
      skid_valid <= 1'b0;
      skid_instr <= NOP_INSTR;
      skid_pc4   <= '0;
    end else if (flush) begin
      main_valid <= 1'b0;
      main_instr <= NOP_INSTR;
      skid_valid <= 1'b0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_instr <= skid_instr;
        main_pc4   <= skid_pc4;
        skid_valid <= accept;
        if (accept) begin
          skid_instr <= in_instr;
          skid_pc4   <= in_pc4;
        end
      end else if (accept) begin
        main_valid <= 1'b1;
        main_instr <= in_instr;
        main_pc4   <= in_pc4;
      end else begin
        main_valid <= 1'b0;
        main_instr <= NOP_INSTR;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_instr <= in_instr;
      skid_pc4   <= in_pc4;
    end
  end

  assign out_valid   = main_valid;
  assign out_instr   = main_instr;
  assign out_pc4     = main_pc4;
  assign out_opcode  = main_instr[31:26];
  assign out_rs      = main_instr[25:21];
  assign out_rt      = main_instr[20:16];
  assign out_rd      = main_instr[15:11];
  assign out_imm     = main_instr[15:0];
  assign out_jtarget = main_instr[25:0];

`ifdef IFID_PERF_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // A main entry drained in the flush cycle belongs to decode, so only a
  // stalled main entry or a held skid entry counts as killed.
  logic flush_kills;
  assign flush_kills = flush && ((main_valid && !out_ready) || skid_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_ONE;
      if (flush_kills && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_ONE;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ifid_skid_reg.sv
// Directed self-checking bench for ifid_skid_reg.
`timescale 1ns/1ps
`default_nettype none

module tb_ifid_skid_reg;
  localparam int PC_W  = 32;
  localparam int CNT_W = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc4;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc4;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [15:0]     out_imm;
  logic [25:0]     out_jtarget;
`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ifid_skid_reg #(.PC_W(PC_W), .NOP_INSTR(32'h0), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc4(in_pc4),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc4(out_pc4),
    .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_imm(out_imm), .out_jtarget(out_jtarget)
`ifdef IFID_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc4 = '0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_instr = 32'hDEADBEEF; in_pc4 = 32'h44;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL reset_out_instr got=%h exp=00000000", out_instr); end
    n_cmp++; if (out_pc4 !== 32'h0) begin n_bad++; $display("FAIL reset_out_pc4 got=%h exp=00000000", out_pc4); end
    rst_n = 1'b1; in_valid = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_idle_valid got=%b exp=0", out_valid); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h8C220004; in_pc4 = 32'h104;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL stream_valid got=%b exp=1", out_valid); end
    n_cmp++; if (out_opcode !== 6'h23) begin n_bad++; $display("FAIL stream_opcode got=%h exp=23", out_opcode); end
    n_cmp++; if (out_rs !== 5'd1) begin n_bad++; $display("FAIL stream_rs got=%0d exp=1", out_rs); end
    n_cmp++; if (out_rt !== 5'd2) begin n_bad++; $display("FAIL stream_rt got=%0d exp=2", out_rt); end
    n_cmp++; if (out_rd !== 5'd0) begin n_bad++; $display("FAIL stream_rd got=%0d exp=0", out_rd); end
    n_cmp++; if (out_imm !== 16'h0004) begin n_bad++; $display("FAIL stream_imm got=%h exp=0004", out_imm); end
    n_cmp++; if (out_jtarget !== 26'h0220004) begin n_bad++; $display("FAIL stream_jtarget got=%h exp=0220004", out_jtarget); end
    n_cmp++; if (out_pc4 !== 32'h104) begin n_bad++; $display("FAIL stream_pc4 got=%h exp=00000104", out_pc4); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL stream_drained_valid got=%b exp=0", out_valid); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL stream_bubble_instr got=%h exp=00000000", out_instr); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hA0000001; in_pc4 = 32'h200;
    step();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_after_a got=%b exp=1", in_ready); end
    in_instr = 32'hB0000002; in_pc4 = 32'h204;
    step();
    n_cmp++; if (out_instr !== 32'hA0000001) begin n_bad++; $display("FAIL bp_hold_a got=%h exp=a0000001", out_instr); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
    in_instr = 32'hC0000003; in_pc4 = 32'h208;
    step();
    n_cmp++; if (out_instr !== 32'hA0000001 || out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_stall_a got=%h/%b exp=a0000001/1", out_instr, out_valid); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_stall got=%b exp=0", in_ready); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_instr !== 32'hB0000002 || out_pc4 !== 32'h204) begin n_bad++; $display("FAIL bp_second_b got=%h/%h exp=b0000002/00000204", out_instr, out_pc4); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_reopen got=%b exp=1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_instr !== 32'hC0000003 || out_pc4 !== 32'h208) begin n_bad++; $display("FAIL bp_third_c got=%h/%h exp=c0000003/00000208", out_instr, out_pc4); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_empty_after got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h11110000; in_pc4 = 32'h300;
    step();
    in_instr = 32'h22220000; in_pc4 = 32'h304;
    step();
    in_instr = 32'h33330000; in_pc4 = 32'h308; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_instr !== 32'h0) begin n_bad++; $display("FAIL flush_instr got=%h exp=00000000", out_instr); end
    n_cmp++; if (out_pc4 !== 32'h300) begin n_bad++; $display("FAIL flush_pc4_hold got=%h exp=00000300", out_pc4); end
    out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_replay got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h44440000; in_pc4 = 32'h400;
    step();
    in_instr = 32'h55550000; in_pc4 = 32'h404;
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_stall_state got=%b/%b exp=0/1", out_valid, in_ready); end
    n_cmp++; if (out_pc4 !== 32'h0) begin n_bad++; $display("FAIL rst_stall_pc4 got=%h exp=00000000", out_pc4); end
    out_ready = 1'b1;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stall_replay got=%b exp=0", out_valid); end
  endtask

`ifdef IFID_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    n_cmp++; if (stall_cnt !== '0 || flush_cnt !== '0) begin n_bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h66660000; in_pc4 = 32'h500;
    step();
    in_instr = 32'h77770000; in_pc4 = 32'h504;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    n_cmp++; if (stall_cnt !== 16'd5) begin n_bad++; $display("FAIL perf_stall got=%0d exp=5", stall_cnt); end
    out_ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd5) begin n_bad++; $display("FAIL perf_flush got=%0d/%0d exp=1/5", flush_cnt, stall_cnt); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    n_cmp++; if (flush_cnt !== 16'd1) begin n_bad++; $display("FAIL perf_empty_flush got=%0d exp=1", flush_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush();
    test_reset_mid_stall();
`ifdef IFID_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
